// File: rtl/obi_copy_master.sv
// obi_copy_master
// ---------------------------------------------------------------------------
// Word-copy engine that acts as the initiator on the req/gnt/rvalid memory
// interface. After a start pulse it copies len words from an ascending
// source pointer to an ascending destination pointer, one bus transaction
// at a time: read, wait for the response, write, wait for the acknowledge.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : start request, honoured only in IDLE
//   src_addr_i    : first source address
//   dst_addr_i    : first destination address
//   len_i         : number of words to copy (0 = finish immediately)
//   abort_i       : stop at the next word boundary
//   busy_o        : a copy is in progress
//   done_o        : one-cycle completion pulse
//   aborted_o     : last copy ended early because of abort_i (sticky)
//   words_done_o  : words whose write has been acknowledged
//   req_o, gnt_i, rvalid_i, addr_o, we_o, wdata_o, rdata_i : bus initiator
// ---------------------------------------------------------------------------
module obi_copy_master #(
  parameter int LEN_W    = 16,
  parameter int ADDR_INC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic             req_o,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [31:0]      wdata_o,
  input  logic [31:0]      rdata_i
);

  localparam logic [31:0] PTR_INC = 32'(ADDR_INC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      src_ptr_reg, src_ptr_next;
  logic [31:0]      dst_ptr_reg, dst_ptr_next;
  logic [31:0]      data_reg, data_next;        // word in flight between read and write
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] words_done_reg, words_done_next;
  logic             aborted_reg, aborted_next;
  logic             abort_pending_reg, abort_pending_next;

  logic [LEN_W-1:0] words_inc;
  logic             last_word;
  logic             stop_req;

  assign words_inc = words_done_reg + LEN_W'(1);
  assign last_word = (words_inc == len_reg);
  // An abort arriving in the same cycle as the write acknowledge still counts.
  assign stop_req  = abort_pending_reg | abort_i;

  assign aborted_o    = aborted_reg;
  assign words_done_o = words_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      src_ptr_reg       <= '0;
      dst_ptr_reg       <= '0;
      data_reg          <= '0;
      len_reg           <= '0;
      words_done_reg    <= '0;
      aborted_reg       <= 1'b0;
      abort_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      src_ptr_reg       <= src_ptr_next;
      dst_ptr_reg       <= dst_ptr_next;
      data_reg          <= data_next;
      len_reg           <= len_next;
      words_done_reg    <= words_done_next;
      aborted_reg       <= aborted_next;
      abort_pending_reg <= abort_pending_next;
    end
  end

  // Bus outputs are decoded from the state register only, so they hold
  // steady while a request waits for its grant and fall to zero the moment
  // reset is applied.
  always_comb begin
    state_next         = state_reg;
    src_ptr_next       = src_ptr_reg;
    dst_ptr_next       = dst_ptr_reg;
    data_next          = data_reg;
    len_next           = len_reg;
    words_done_next    = words_done_reg;
    aborted_next       = aborted_reg;
    abort_pending_next = abort_pending_reg;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    req_o              = 1'b0;
    we_o               = 1'b0;
    addr_o             = '0;
    wdata_o            = '0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          words_done_next = '0;
          aborted_next    = 1'b0;
          if (len_i != '0) begin
            src_ptr_next = src_addr_i;
            dst_ptr_next = dst_addr_i;
            len_next     = len_i;
            state_next   = RD_REQ;
          end else begin
            state_next   = DONE;
          end
        end
      end

      RD_REQ: begin
        busy_o = 1'b1;
        req_o  = 1'b1;
        addr_o = src_ptr_reg;
        if (gnt_i) state_next = RD_WAIT;
      end

      RD_WAIT: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          data_next  = rdata_i;
          state_next = WR_REQ;
        end
      end

      WR_REQ: begin
        busy_o  = 1'b1;
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = dst_ptr_reg;
        wdata_o = data_reg;
        if (gnt_i) state_next = WR_WAIT;
      end

      WR_WAIT: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          words_done_next = words_inc;
          src_ptr_next    = src_ptr_reg + PTR_INC;
          dst_ptr_next    = dst_ptr_reg + PTR_INC;
          if (last_word || stop_req) begin
            state_next   = DONE;
            // Only flag an abort if it actually cut the copy short.
            aborted_next = stop_req && !last_word;
          end else begin
            state_next   = RD_REQ;
          end
        end
      end

      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Sticky abort request, collected only while a copy is running.
    abort_pending_next = abort_pending_reg | (busy_o & abort_i);
    if (state_next == DONE) abort_pending_next = 1'b0;
  end

endmodule
